// File: rtl/bg_pkg.sv
// rtl/bg_pkg.sv - shared field positions, types and rank-key helper for the background merger
package bg_pkg;

    localparam int PRIO_HI    = 19;
    localparam int PRIO_LO    = 18;
    localparam int BITMAP_BIT = 16;
    localparam int VIS_BIT    = 15;
    localparam int PAYLOAD_W  = 15;

    // Rank key: {~visible, priority[1:0], bg_index[1:0]}; MSB set means not visible
    localparam int KEY_W       = 5;
    localparam int KEY_HID_BIT = 4;

    typedef logic [19:0]        formatted_t;
    typedef logic [2:0]         layer_id_t;
    typedef logic [KEY_W-1:0]   rank_key_t;
    typedef logic [PAYLOAD_W-1:0] payload_t;

    localparam layer_id_t LAYER_BACKDROP = 3'd4;

    // Smaller key wins: visible beats hidden, then lower priority, then lower BG index
    function automatic rank_key_t make_key(input formatted_t w, input logic [1:0] n);
        return {~w[VIS_BIT], w[PRIO_HI:PRIO_LO], n};
    endfunction

    function automatic logic is_bitmapped(input formatted_t w);
        return w[BITMAP_BIT];
    endfunction

endpackage

// File: rtl/bg_rank_select.sv
// rtl/bg_rank_select.sv - combinational min and second-min search over four rank keys
module bg_rank_select
    import bg_pkg::*;
(
    input  rank_key_t [3:0] keys,
    output logic [1:0]      top_idx,
    output logic [1:0]      second_idx
);

    localparam int N_KEYS = 4;

    logic [1:0] top_sel;
    logic [1:0] sec_sel;

    // Keys embed the BG index so they are always distinct; strict compare is enough
    always_comb begin
        top_sel = 2'd0;
        for (int i = 1; i < N_KEYS; i++) begin
            if (keys[i] < keys[top_sel]) begin
                top_sel = 2'(i);
            end
        end
        sec_sel = (top_sel == 2'd0) ? 2'd1 : 2'd0;
        for (int i = 0; i < N_KEYS; i++) begin
            if ((2'(i) != top_sel) && (keys[i] < keys[sec_sel])) begin
                sec_sel = 2'(i);
            end
        end
        top_idx    = top_sel;
        second_idx = sec_sel;
    end

endmodule

// File: rtl/bg_priority_merger.sv
// rtl/bg_priority_merger.sv - two-stage top/second background layer selector with x tracking
module bg_priority_merger
    import bg_pkg::*;
#(
    parameter int NUM_BG      = 4,
    parameter int LINE_PIXELS = 240,
    parameter int XW          = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   line_start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_BG*20-1:0]   bg_words,
    output logic                   out_valid,
    input  logic                   out_ready,
    output formatted_t             top_word,
    output layer_id_t              top_layer,
    output formatted_t             second_word,
    output layer_id_t              second_layer,
    output logic [XW-1:0]          pixel_x,
    output logic                   last_pixel
);

    localparam logic [XW-1:0] X_LAST = XW'(LINE_PIXELS - 1);

    logic s2_adv;
    logic s1_adv;
    logic accept;

    logic [XW-1:0] x_in;
    logic [XW-1:0] x_cnt_q, x_cnt_d;

    logic                        s1_valid_q, s1_valid_d;
    formatted_t [NUM_BG-1:0]     s1_words_q, s1_words_d;
    rank_key_t  [NUM_BG-1:0]     s1_keys_q,  s1_keys_d;
    logic [XW-1:0]               s1_x_q,     s1_x_d;

    logic          s2_valid_q,        s2_valid_d;
    formatted_t    top_word_q,        top_word_d;
    layer_id_t     top_layer_q,       top_layer_d;
    formatted_t    second_word_q,     second_word_d;
    layer_id_t     second_layer_q,    second_layer_d;
    logic [XW-1:0] pixel_x_q,         pixel_x_d;
    logic          last_pixel_q,      last_pixel_d;

    logic [1:0] top_idx;
    logic [1:0] second_idx;
    logic       top_vis;
    logic       second_vis;

    // Handshake: each stage moves when its downstream slot is free or draining
    always_comb begin
        s2_adv = ~s2_valid_q | out_ready;
        s1_adv = ~s1_valid_q | s2_adv;
        accept = in_valid & s1_adv;
    end

    // Input-side x counter; line_start zeroes the x used by a same-cycle accept
    always_comb begin
        x_in    = line_start ? '0 : x_cnt_q;
        x_cnt_d = x_cnt_q;
        if (accept) begin
            x_cnt_d = (x_in == X_LAST) ? '0 : x_in + 1'b1;
        end else if (line_start) begin
            x_cnt_d = '0;
        end
    end

    // Stage 1: capture words, their rank keys and the pixel x on accept
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_words_d = s1_words_q;
        s1_keys_d  = s1_keys_q;
        s1_x_d     = s1_x_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
        end
        if (accept) begin
            for (int n = 0; n < NUM_BG; n++) begin
                s1_words_d[n] = bg_words[20*n +: 20];
                s1_keys_d[n]  = make_key(bg_words[20*n +: 20], 2'(n));
            end
            s1_x_d = x_in;
        end
    end

    bg_rank_select u_rank (
        .keys       (s1_keys_q),
        .top_idx    (top_idx),
        .second_idx (second_idx)
    );

    // Stage 2: register winners, replacing hidden ones with the backdrop
    always_comb begin
        top_vis        = ~s1_keys_q[top_idx][KEY_HID_BIT];
        second_vis     = ~s1_keys_q[second_idx][KEY_HID_BIT];
        s2_valid_d     = s2_valid_q;
        top_word_d     = top_word_q;
        top_layer_d    = top_layer_q;
        second_word_d  = second_word_q;
        second_layer_d = second_layer_q;
        pixel_x_d      = pixel_x_q;
        last_pixel_d   = last_pixel_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_adv && s1_valid_q) begin
            top_word_d     = top_vis    ? s1_words_q[top_idx]    : '0;
            top_layer_d    = top_vis    ? {1'b0, top_idx}        : LAYER_BACKDROP;
            second_word_d  = second_vis ? s1_words_q[second_idx] : '0;
            second_layer_d = second_vis ? {1'b0, second_idx}     : LAYER_BACKDROP;
            pixel_x_d      = s1_x_q;
            last_pixel_d   = (s1_x_q == X_LAST);
        end
    end

    // State registers with synchronous reset; in-flight pixels are discarded
    always_ff @(posedge clock) begin
        if (reset) begin
            x_cnt_q        <= '0;
            s1_valid_q     <= 1'b0;
            s1_words_q     <= '0;
            s1_keys_q      <= '0;
            s1_x_q         <= '0;
            s2_valid_q     <= 1'b0;
            top_word_q     <= '0;
            top_layer_q    <= LAYER_BACKDROP;
            second_word_q  <= '0;
            second_layer_q <= LAYER_BACKDROP;
            pixel_x_q      <= '0;
            last_pixel_q   <= 1'b0;
        end else begin
            x_cnt_q        <= x_cnt_d;
            s1_valid_q     <= s1_valid_d;
            s1_words_q     <= s1_words_d;
            s1_keys_q      <= s1_keys_d;
            s1_x_q         <= s1_x_d;
            s2_valid_q     <= s2_valid_d;
            top_word_q     <= top_word_d;
            top_layer_q    <= top_layer_d;
            second_word_q  <= second_word_d;
            second_layer_q <= second_layer_d;
            pixel_x_q      <= pixel_x_d;
            last_pixel_q   <= last_pixel_d;
        end
    end

    assign in_ready     = s1_adv;
    assign out_valid    = s2_valid_q;
    assign top_word     = top_word_q;
    assign top_layer    = top_layer_q;
    assign second_word  = second_word_q;
    assign second_layer = second_layer_q;
    assign pixel_x      = pixel_x_q;
    assign last_pixel   = last_pixel_q;

endmodule

// File: tb/tb_bg_priority_merger.sv
// tb/tb_bg_priority_merger.sv - directed self-checking bench with a queue-based reference model
module tb_bg_priority_merger;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        line_start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [79:0] bg_words = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [19:0] top_word;
    logic [2:0]  top_layer;
    logic [19:0] second_word;
    logic [2:0]  second_layer;
    logic [7:0]  pixel_x;
    logic        last_pixel;

    always #5 clock = ~clock;

    bg_priority_merger #(.NUM_BG(4), .LINE_PIXELS(240), .XW(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .line_start   (line_start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .bg_words     (bg_words),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .top_word     (top_word),
        .top_layer    (top_layer),
        .second_word  (second_word),
        .second_layer (second_layer),
        .pixel_x      (pixel_x),
        .last_pixel   (last_pixel)
    );

    typedef struct {
        logic [19:0] tw;
        logic [2:0]  tl;
        logic [19:0] sw;
        logic [2:0]  sl;
        int          x;
        bit          last;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t e;
    int   mx = 0;
    int   lasts = 0;
    bit   post_rst = 1'b0;
    bit   prev_stall = 1'b0;
    logic [19:0] h_tw, h_sw;
    logic [2:0]  h_tl, h_sl;
    logic [7:0]  h_x;
    logic        h_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] mkw(input int prio, input bit bm, input bit vis, input int pay);
        logic [1:0]  p2 = 2'(prio);
        logic [14:0] pl = 15'(pay);
        return {p2, 1'b0, bm, vis, pl};
    endfunction

    // Visible BGs listed in winning order: priority ascending, then index ascending
    function automatic exp_t model(input logic [79:0] w, input int x);
        int          order[$];
        logic [19:0] wn;
        exp_t        r;
        for (int p = 0; p < 4; p++) begin
            for (int n = 0; n < 4; n++) begin
                wn = w[20*n +: 20];
                if (wn[15] && (int'(wn[19:18]) == p)) order.push_back(n);
            end
        end
        r.tl = (order.size() > 0) ? 3'(order[0]) : 3'd4;
        r.tw = (order.size() > 0) ? w[20*order[0] +: 20] : 20'h0;
        r.sl = (order.size() > 1) ? 3'(order[1]) : 3'd4;
        r.sw = (order.size() > 1) ? w[20*order[1] +: 20] : 20'h0;
        r.x    = x;
        r.last = (x == 239);
        return r;
    endfunction

    function automatic logic [79:0] rnd_words();
        logic [79:0] w;
        for (int n = 0; n < 4; n++) begin
            w[20*n +: 20] = mkw($urandom_range(3), 1'($urandom_range(1)),
                                1'($urandom_range(1)), $urandom_range(32767));
        end
        return w;
    endfunction

    // Compare process: checks DUT against the model queue every cycle, mid-cycle
    always @(negedge clock) begin
        if (reset) begin
            q.delete();
            mx = 0;
            post_rst = 1'b1;
            prev_stall = 1'b0;
        end else begin
            if (post_rst) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_top_word", top_word, 0);
                chk("rst_second_word", second_word, 0);
                chk("rst_top_layer", top_layer, 4);
                chk("rst_second_layer", second_layer, 4);
                chk("rst_pixel_x", pixel_x, 0);
                chk("rst_last_pixel", last_pixel, 0);
                chk("rst_in_ready", in_ready, 1);
                post_rst = 1'b0;
            end
            chk("in_ready", in_ready, (q.size() < 2 || out_ready) ? 1 : 0);
            if (prev_stall) begin
                chk("hold", {top_word, top_layer, second_word, second_layer, pixel_x, last_pixel},
                            {h_tw, h_tl, h_sw, h_sl, h_x, h_last});
                chk("hold_valid", out_valid, 1);
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    e = q[0];
                    chk("top_word", top_word, e.tw);
                    chk("top_layer", top_layer, e.tl);
                    chk("second_word", second_word, e.sw);
                    chk("second_layer", second_layer, e.sl);
                    chk("pixel_x", pixel_x, e.x);
                    chk("last_pixel", last_pixel, e.last);
                    if (out_ready) begin
                        if (last_pixel) lasts++;
                        void'(q.pop_front());
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            {h_tw, h_tl, h_sw, h_sl, h_x, h_last} =
                {top_word, top_layer, second_word, second_layer, pixel_x, last_pixel};
            if (in_valid && in_ready) begin
                int xa;
                xa = line_start ? 0 : mx;
                q.push_back(model(bg_words, xa));
                mx = (xa == 239) ? 0 : xa + 1;
            end else if (line_start) begin
                mx = 0;
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge
    task automatic send(input logic [79:0] w, input bit ls);
        bit ok;
        ok = 1'b0;
        bg_words = w;
        line_start = ls;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clock);
            ok = in_ready;
        end
        if (!ok) chk("send_timeout", 0, 1);
        else begin
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        line_start = 1'b0;
    endtask

    task automatic wait_out();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clock);
            ok = out_valid;
        end
        if (!ok) chk("wait_out_timeout", 0, 1);
    endtask

    task automatic drain();
        repeat (6) @(negedge clock);
        chk("drain_empty", q.size(), 0);
        @(posedge clock);
        #1;
    endtask

    logic [79:0] w;
    logic [19:0] w0, w1, w3;

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;

        // Single pixel: BG1 prio 1 beats BG0 prio 2; two-cycle latency, x = 0
        w0 = mkw(2, 0, 1, 15'h1234);
        w1 = mkw(1, 1, 1, 15'h7abc);
        w = {mkw(0, 0, 0, 15'h0055), mkw(0, 0, 0, 15'h00aa), w1, w0};
        send(w, 1'b0);
        @(negedge clock);
        chk("lat_not_yet", out_valid, 0);
        @(negedge clock);
        chk("lat_valid", out_valid, 1);
        chk("t1_top_layer", top_layer, 1);
        chk("t1_second_layer", second_layer, 0);
        chk("t1_pixel_x", pixel_x, 0);
        chk("t1_top_word", top_word, 20'h5fabc);
        drain();

        // All visible priority 0: index tie-break, bit-exact words
        w0 = mkw(0, 1, 1, 15'h2a5a);
        w1 = mkw(0, 0, 1, 15'h55a5);
        w = {mkw(0, 0, 1, 3), mkw(0, 1, 1, 2), w1, w0};
        send(w, 1'b0);
        wait_out();
        chk("t2_top_layer", top_layer, 0);
        chk("t2_second_layer", second_layer, 1);
        chk("t2_top_word", top_word, 20'h1aa5a);
        chk("t2_second_word", second_word, 20'h0d5a5);
        drain();

        // None visible, then only BG3 visible
        w = {mkw(0, 0, 0, 9), mkw(1, 0, 0, 8), mkw(2, 1, 0, 7), mkw(3, 0, 0, 6)};
        send(w, 1'b0);
        wait_out();
        chk("t3_top_layer", top_layer, 4);
        chk("t3_second_layer", second_layer, 4);
        chk("t3_words", {top_word, second_word}, 40'h0);
        drain();
        w3 = mkw(3, 0, 1, 15'h0101);
        w = {w3, mkw(0, 0, 0, 1), mkw(0, 0, 0, 2), mkw(0, 0, 0, 3)};
        send(w, 1'b0);
        wait_out();
        chk("t3b_top_layer", top_layer, 3);
        chk("t3b_second_layer", second_layer, 4);
        chk("t3b_top_word", top_word, 20'hc8101);
        drain();

        // Full line of 240 pixels plus one, starting from a line_start
        send(rnd_words(), 1'b1);
        for (int i = 1; i < 241; i++) send(rnd_words(), 1'b0);
        drain();
        chk("last_count", lasts, 1);
        for (int i = 0; i < 100; i++) send(rnd_words(), 1'b0);
        send(rnd_words(), 1'b1);
        wait_out();
        for (int i = 0; i < 5; i++) send(rnd_words(), 1'b0);
        drain();
        chk("last_count_after_restart", lasts, 1);

        // Backpressure: out_ready low for 5 cycles mid-stream
        fork
            begin
                for (int i = 0; i < 20; i++) send(rnd_words(), 1'b0);
            end
            begin
                repeat (6) @(posedge clock);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clock);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with both stages full
        out_ready = 1'b0;
        send(rnd_words(), 1'b0);
        send(rnd_words(), 1'b0);
        @(negedge clock);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        w = {mkw(1, 0, 1, 4), mkw(1, 0, 1, 3), mkw(2, 0, 0, 2), mkw(3, 0, 1, 1)};
        send(w, 1'b0);
        wait_out();
        chk("post_rst_pixel_x", pixel_x, 0);
        chk("post_rst_top_layer", top_layer, 2);
        chk("post_rst_second_layer", second_layer, 3);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
